md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl_if.sv | 29 ++
 rtl/md_ctrl.sv | 156 +++++++++++++++
 tb/tb_md_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/md_ctrl_if.sv
// Handshake, operand and HI/LO access signals between the EXE stage and md_ctrl.
// The pipeline drives through the master modport, and md_ctrl sits on the slave modport.
interface md_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        cancel;
  logic        out_allowin;
  logic        md_ready_go;
  logic        md_busy;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        rd_hi;
  logic [31:0] hilo_rdata;

  modport master (
    output req_valid, req_op, src1, src2, cancel, out_allowin,
           wr_hi, wr_lo, wdata, rd_hi,
    input  md_ready_go, md_busy, hilo_rdata
  );

  modport slave (
    input  req_valid, req_op, src1, src2, cancel, out_allowin,
           wr_hi, wr_lo, wdata, rd_hi,
    output md_ready_go, md_busy, hilo_rdata
  );
endinterface

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the EXE stage, which owns the HI/LO registers.
// It uses a single-cycle registered multiply and a 32-cycle radix-2 restoring divide.
module md_ctrl (
  input  logic     clk,
  input  logic     reset,
  md_ctrl_if.slave md
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // In DIV, a_q is the dividend, which shifts out while the quotient shifts in, and b_q is the divisor.
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] res_q, res_d;
  logic        signed_q, signed_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        is_signed;
  logic [31:0] mag1, mag2;
  logic [63:0] ext_a, ext_b, product;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] rem_next, quo_next;
  logic        commit;

  always_comb begin
    is_signed = ~md.req_op[0];
    mag1      = (is_signed && md.src1[31]) ? -md.src1 : md.src1;
    mag2      = (is_signed && md.src2[31]) ? -md.src2 : md.src2;

    // The low 64 bits of a product of extended operands are the same for signed and unsigned multiplies.
    ext_a   = {{32{signed_q & a_q[31]}}, a_q};
    ext_b   = {{32{signed_q & b_q[31]}}, b_q};
    product = ext_a * ext_b;

    shifted  = {rem_q, a_q[31]};
    fits     = (shifted >= {1'b0, b_q});
    rem_next = fits ? (shifted[31:0] - b_q) : shifted[31:0];
    quo_next = {a_q[30:0], fits};
  end

  // NOTE: every next-state variable receives a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    res_d    = res_q;
    signed_d = signed_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    commit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (md.req_valid) begin
          signed_d = is_signed;
          cnt_d    = 5'd0;
          rem_d    = 32'd0;
          if (md.req_op[1]) begin
            a_d     = mag1;
            b_d     = mag2;
            qneg_d  = is_signed & (md.src1[31] ^ md.src2[31]);
            rneg_d  = is_signed & md.src1[31];
            state_d = S_DIV;
          end else begin
            a_d     = md.src1;
            b_d     = md.src2;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        res_d   = product;
        state_d = S_DONE;
      end
      S_DIV: begin
        a_d   = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          res_d   = {rneg_q ? -rem_next : rem_next, qneg_q ? -quo_next : quo_next};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (md.out_allowin) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An exception flushes everything; it has priority over both launch and commit.
    if (md.cancel) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      commit  = 1'b0;
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      hi_d = res_q[63:32];
      lo_d = res_q[31:0];
    end else begin
      if (md.wr_hi) hi_d = md.wdata;
      if (md.wr_lo) lo_d = md.wdata;
    end
  end

  // NOTE: non-blocking assignments only in clocked blocks, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: datapath registers have no reset; each one is loaded before the FSM reads it.
  always_ff @(posedge clk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    rem_q    <= rem_d;
    res_q    <= res_d;
    signed_q <= signed_d;
    qneg_q   <= qneg_d;
    rneg_q   <= rneg_d;
  end

  assign md.md_busy     = (state_q != S_IDLE);
  assign md.md_ready_go = (state_q == S_DONE) || ((state_q == S_IDLE) && !md.req_valid);
  assign md.hilo_rdata  = md.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed-vector bench for md_ctrl. The expected results are computed by hand from the operand values.
module tb_md_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  md_ctrl_if bus ();

  md_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.rd_hi = 1'b1;
    #1;
    check({tag, ".hi"}, {32'd0, bus.hilo_rdata}, {32'd0, exp_hi});
    bus.rd_hi = 1'b0;
    #1;
    check({tag, ".lo"}, {32'd0, bus.hilo_rdata}, {32'd0, exp_lo});
  endtask

  // Launches an operation in the current cycle (cycle 0), checks md_ready_go in every cycle through DONE,
  // commits with out_allowin high, and then checks HI/LO.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.src1        = a;
    bus.src2        = b;
    bus.out_allowin = 1'b1;
    #1;
    for (int c = 0; c <= lat; c++) begin
      check($sformatf("%s.ready_go.c%0d", tag, c), {63'd0, bus.md_ready_go}, {63'd0, (c == lat)});
      if (c < lat) step();
    end
    check({tag, ".busy_done"}, {63'd0, bus.md_busy}, 64'd1);
    step();
    bus.req_valid = 1'b0;
    check({tag, ".busy_after"}, {63'd0, bus.md_busy}, 64'd0);
    check_hilo(tag, exp_hi, exp_lo);
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_op      = 2'b00;
    bus.src1        = 32'd0;
    bus.src2        = 32'd0;
    bus.cancel      = 1'b0;
    bus.out_allowin = 1'b1;
    bus.wr_hi       = 1'b0;
    bus.wr_lo       = 1'b0;
    bus.wdata       = 32'd0;
    bus.rd_hi       = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst.busy", {63'd0, bus.md_busy}, 64'd0);
    check("rst.ready_go", {63'd0, bus.md_ready_go}, 64'd1);
    check_hilo("rst", 32'h0, 32'h0);

    // Multiply and divide vectors, issued back to back.
    run_op("mult_m1x2", 2'b00, 32'hFFFFFFFF, 32'h00000002, 2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 33, 32'h00000002, 32'h0000000E);
    run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_by0", 2'b11, 32'h12345678, 32'h00000000, 33, 32'h12345678, 32'hFFFFFFFF);
    run_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);
    run_op("mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 2, 32'h40000000, 32'h00000000);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 32'h00000001);

    // MTHI/MTLO while idle.
    bus.wr_hi = 1'b1;
    bus.wr_lo = 1'b0;
    bus.wdata = 32'h11111111;
    step();
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h22222222;
    step();
    bus.wr_lo = 1'b0;
    check_hilo("mtx", 32'h11111111, 32'h22222222);

    // Cancel a DIV in cycle 10; HI/LO must keep their pre-launch values.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b11;
    bus.src1      = 32'd1000;
    bus.src2      = 32'd3;
    for (int c = 0; c < 10; c++) step();
    check("cancel.busy_c10", {63'd0, bus.md_busy}, 64'd1);
    bus.cancel = 1'b1;
    step();
    bus.cancel    = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("cancel.busy_c11", {63'd0, bus.md_busy}, 64'd0);
    check("cancel.ready_go_c11", {63'd0, bus.md_ready_go}, 64'd1);
    for (int c = 0; c < 30; c++) step();
    check_hilo("cancel", 32'h11111111, 32'h22222222);

    // Cancel has priority over launch.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.cancel    = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.cancel    = 1'b0;
    #1;
    check("cancel_launch.busy", {63'd0, bus.md_busy}, 64'd0);

    // MULTU 3*5 held in DONE for 3 cycles, with an MTHI during the hold and an MTLO at commit.
    bus.req_valid   = 1'b1;
    bus.req_op      = 2'b01;
    bus.src1        = 32'd3;
    bus.src2        = 32'd5;
    bus.out_allowin = 1'b0;
    step();
    step();
    bus.wr_hi = 1'b1;
    bus.wdata = 32'hAAAAAAAA;
    #1;
    check("hold.ready_go_c2", {63'd0, bus.md_ready_go}, 64'd1);
    check_hilo("hold.nobypass", 32'h11111111, 32'h22222222);
    step();
    bus.wr_hi = 1'b0;
    check_hilo("hold.c3", 32'hAAAAAAAA, 32'h22222222);
    check("hold.busy_c3", {63'd0, bus.md_busy}, 64'd1);
    step();
    check("hold.busy_c4", {63'd0, bus.md_busy}, 64'd1);
    step();
    bus.out_allowin = 1'b1;
    bus.wr_lo       = 1'b1;
    bus.wdata       = 32'h55555555;
    step();
    bus.req_valid = 1'b0;
    bus.wr_lo     = 1'b0;
    check("hold.busy_after", {63'd0, bus.md_busy}, 64'd0);
    check_hilo("hold.commit", 32'h00000000, 32'h0000000F);

    // Cancel in DONE suppresses the commit.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.src1      = 32'd7;
    bus.src2      = 32'd9;
    step();
    step();
    bus.cancel = 1'b1;
    step();
    bus.cancel    = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("cancel_done.busy", {63'd0, bus.md_busy}, 64'd0);
    check_hilo("cancel_done", 32'h00000000, 32'h0000000F);

    // Reset in the middle of a DIV.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.src1      = 32'd50;
    bus.src2      = 32'd5;
    for (int c = 0; c < 5; c++) step();
    reset = 1'b1;
    step();
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("rst_mid.busy", {63'd0, bus.md_busy}, 64'd0);
    check("rst_mid.ready_go", {63'd0, bus.md_ready_go}, 64'd1);
    for (int c = 0; c < 35; c++) step();
    check_hilo("rst_mid", 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
